b_multu: RTL and testbench
==========================

Name: b_multu

Overview:
- Iterative unsigned multiplier with the architectural HI/LO register pair. Sits in the EX stage alongside the ALU.
- Consumes the multu decode produced by ALU control (R-type, funct 011001) and supplies HI/LO to the mfhi/mflo path.
- Runs a shift-add sequence of DATA_W cycles. It raises a busy flag so the hazard unit can stall any later multu, mfhi or mflo.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.
- CNT_W, $clog2(DATA_W), iteration counter width.

Ports:
- i_b_multu_clk  input  1  clock, rising edge.
- i_b_multu_rst_n  input  1  asynchronous active-low reset.
- i_b_multu_start  input  1  multu issued in EX this cycle (ALU-control multu decode AND EX valid).
- i_b_multu_flush  input  1  EX flush (branch/jump squash); aborts any multiply in progress.
- i_b_multu_rs  input  DATA_W  multiplicand (rs).
- i_b_multu_rt  input  DATA_W  multiplier (rt).
- o_b_multu_busy  output  1  registered; high while an iteration is in progress.
- o_b_multu_done  output  1  registered; one-cycle pulse when HI/LO is committed.
- o_b_multu_hi  output  DATA_W  architectural HI (upper product half).
- o_b_multu_lo  output  DATA_W  architectural LO (lower product half).

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - state = IDLE; busy = 0; done = 0; HI = LO = 0; counter and working registers = 0.
- States: IDLE, BUSY, DONE.
- IDLE or DONE, start = 1, flush = 0:
  - At the clock edge: load multiplicand M = rs; P = {DATA_W+1 zeros, rt}; counter = DATA_W-1.
  - Go to BUSY; busy = 1 from the next cycle.
- BUSY, one step per edge:
  - If P[0] = 1, upper part (DATA_W+1 bits) = upper + M, with the carry kept.
  - Then P is shifted right logically by 1.
  - Counter decrements by 1.
- BUSY with counter = 0: the step completes, then on the same edge:
  - HI = P[2*DATA_W-1:DATA_W] and LO = P[DATA_W-1:0], taken from the post-step value.
  - state = DONE, busy = 0, done = 1.
- DONE: lasts one cycle, then IDLE; done returns to 0.
  - A start during DONE is accepted exactly as from IDLE (back-to-back multu).
- Latency:
  - Start is sampled at edge k; busy is high for cycles k..k+DATA_W-1.
  - HI/LO take the new value and done = 1 after edge k+DATA_W, i.e. DATA_W cycles.
  - Latency is fixed and does not depend on the operand values (no early termination).
- Result is the exact unsigned product: rs*rt modulo 2^(2*DATA_W), never truncated.
- HI/LO hold their old values for the whole of BUSY. Only the completion edge writes them.
- start while BUSY: ignored, with no effect on the running operation. The hazard unit must prevent this; the bench flags it as a protocol error.
- flush while BUSY:
  - At the next edge: state = IDLE, busy = 0, done stays 0.
  - HI/LO are unchanged and the working registers are discarded.
- flush and start in the same cycle: flush wins; no operation starts.
- Reset mid-operation: everything returns to reset values immediately; a partial product is never committed.
- Outputs are registered only; there is no combinational path from start to busy.
  - The hazard unit treats (start OR busy) as "multiply pending".

Test Plan:
- Reset with rst_n = 0 for 2 cycles -> busy = 0, done = 0, HI = 0x00000000, LO = 0x00000000.
- start with rs = 3, rt = 5 -> busy high for exactly 32 cycles; done pulses once; HI = 0x00000000, LO = 0x0000000F.
- rs = 0xFFFFFFFF, rt = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001.
- Back-to-back run:
  - First multiply 0x80000000 × 2 -> HI = 0x00000001, LO = 0x00000000.
  - Assert start in the DONE cycle with rs = 7, rt = 6 -> second run accepted at once.
  - During the second run HI/LO keep (1, 0); after 32 cycles HI = 0, LO = 0x2A.
- Start with rs = 0x1234, rt = 0x10, then flush on busy cycle 10 -> busy = 0 on the next cycle, no done pulse, HI/LO keep their previous values.
- Interference and reset cases:
  - Pulse start again during busy cycle 5 with different operands -> ignored; the original product is committed after 32 cycles.
  - Drop rst_n mid-run, asynchronously between edges -> HI, LO, busy and done go to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/b_multu.sv
// Iterative unsigned shift-add multiplier with the architectural HI/LO pair.
// Fixed DATA_W-cycle latency; busy/done are registered for the hazard unit.
module b_multu #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              i_b_multu_clk,
    input  logic              i_b_multu_rst_n,
    input  logic              i_b_multu_start,
    input  logic              i_b_multu_flush,
    input  logic [DATA_W-1:0] i_b_multu_rs,
    input  logic [DATA_W-1:0] i_b_multu_rt,
    output logic              o_b_multu_busy,
    output logic              o_b_multu_done,
    output logic [DATA_W-1:0] o_b_multu_hi,
    output logic [DATA_W-1:0] o_b_multu_lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_m, w_m_nxt;
    logic [2*DATA_W:0]   r_p, w_p_nxt;
    logic [DATA_W-1:0]   r_hi, w_hi_nxt;
    logic [DATA_W-1:0]   r_lo, w_lo_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;

    logic [DATA_W:0]     w_upper_sum;
    logic [2*DATA_W:0]   w_p_step;

    // The upper part is DATA_W+1 bits wide so the add carry survives the shift.
    assign w_upper_sum = r_p[0] ? (r_p[2*DATA_W:DATA_W] + {1'b0, r_m})
                                : r_p[2*DATA_W:DATA_W];
    assign w_p_step    = {1'b0, w_upper_sum, r_p[DATA_W-1:1]};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_m_nxt     = r_m;
        w_p_nxt     = r_p;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (i_b_multu_start && !i_b_multu_flush) begin
                    w_m_nxt     = i_b_multu_rs;
                    w_p_nxt     = {{(DATA_W+1){1'b0}}, i_b_multu_rt};
                    w_cnt_nxt   = CNT_W'(DATA_W-1);
                    w_state_nxt = BUSY;
                    w_busy_nxt  = 1'b1;
                end
            end
            BUSY: begin
                if (i_b_multu_flush) begin
                    w_state_nxt = IDLE;
                    w_m_nxt     = '0;
                    w_p_nxt     = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_p_nxt    = w_p_step;
                    w_cnt_nxt  = r_cnt - 1'b1;
                    w_busy_nxt = 1'b1;
                    if (r_cnt == '0) begin
                        // Commit from the post-step value on the final edge.
                        w_hi_nxt    = w_p_step[2*DATA_W-1:DATA_W];
                        w_lo_nxt    = w_p_step[DATA_W-1:0];
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_b_multu_clk or negedge i_b_multu_rst_n) begin
        if (!i_b_multu_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_p     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_m     <= w_m_nxt;
            r_p     <= w_p_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_b_multu_busy = r_busy;
    assign o_b_multu_done = r_done;
    assign o_b_multu_hi   = r_hi;
    assign o_b_multu_lo   = r_lo;

endmodule

// File: tb/tb_b_multu.sv
// Self-checking bench for b_multu: vector table, random products against a
// 64-bit arithmetic model, and hand sequences for flush/interference/reset.
module tb_b_multu;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] rs    = '0;
    logic [W-1:0] rt    = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    b_multu #(.DATA_W(W)) dut (
        .i_b_multu_clk   (clk),
        .i_b_multu_rst_n (rst_n),
        .i_b_multu_start (start),
        .i_b_multu_flush (flush),
        .i_b_multu_rs    (rs),
        .i_b_multu_rt    (rt),
        .o_b_multu_busy  (busy),
        .o_b_multu_done  (done),
        .o_b_multu_hi    (hi),
        .o_b_multu_lo    (lo)
    );

    typedef struct {
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one multu (from IDLE or DONE) and returns in the DONE cycle.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                            input int interfere_at, input string name);
        logic [W-1:0] old_hi;
        logic [W-1:0] old_lo;
        int           busy_cycles;
        bit           held;
        bit           early_done;
        old_hi      = hi;
        old_lo      = lo;
        busy_cycles = 0;
        held        = 1'b1;
        early_done  = 1'b0;
        rs    = a;
        rt    = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            if (hi !== old_hi || lo !== old_lo) held = 1'b0;
            if (done) early_done = 1'b1;
            if (busy_cycles == interfere_at) begin
                $display("note: protocol error injected (start while busy) in %s", name);
                rs    = ~a;
                rt    = b + 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({name, " busy cycles"}, 64'(busy_cycles), 64'(W));
        check({name, " hi/lo held"}, 64'(held), 64'd1);
        check({name, " no early done"}, 64'(early_done), 64'd0);
        check({name, " done pulse"}, 64'(done), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [63:0]  prod;
        logic [W-1:0] keep_hi;
        logic [W-1:0] keep_lo;
        bit           saw_done;

        vecs[0] = '{32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, "3x5"};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "max x max"};
        vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, "zero x"};
        vecs[3] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "one x"};
        vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "2^16 sq"};
        vecs[5] = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, "carry"};

        // Reset for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_mult(vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, 0, vecs[i].name);
            tick();
            check({vecs[i].name, " done drops"}, 64'(done), 64'd0);
        end

        // Back-to-back: second start issued in the DONE cycle.
        run_mult(32'h8000_0000, 32'd2, 32'd1, 32'd0, 0, "b2b first");
        run_mult(32'd7, 32'd6, 32'd0, 32'h2A, 0, "b2b second");
        tick();
        check("b2b done drops", 64'(done), 64'd0);

        // Flush on busy cycle 10.
        keep_hi = hi;
        keep_lo = lo;
        rs    = 32'h1234;
        rt    = 32'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre-flush busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        check("flush no later activity", 64'(saw_done), 64'd0);
        check("flush hi kept", 64'(hi), 64'(keep_hi));
        check("flush lo kept", 64'(lo), 64'(keep_lo));

        // Start and flush together: flush wins.
        rs    = 32'd5;
        rt    = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("start+flush busy", 64'(busy), 64'd0);
        tick();
        check("start+flush done", 64'(done), 64'd0);
        check("start+flush lo kept", 64'(lo), 64'(keep_lo));

        // Start during busy cycle 5 is ignored.
        run_mult(32'h0000_0055, 32'd3, 32'd0, 32'hFF, 5, "ignored start");
        tick();
        check("ignored start settles", 64'(busy), 64'd0);

        // Randomized products against plain 64-bit arithmetic.
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 7 == 3) b = '1;
            if (i % 7 == 5) a = 32'h8000_0000 | a;
            prod = {32'd0, a} * {32'd0, b};
            run_mult(a, b, prod[63:32], prod[31:0], 0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // Asynchronous reset mid-run, between clock edges.
        run_mult(32'd3, 32'd5, 32'd0, 32'hF, 0, "pre-reset");
        tick();
        rs    = 32'd9;
        rt    = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        check("async rst hi", 64'(hi), 64'd0);
        check("async rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("post-reset idle", 64'(saw_done), 64'd0);
        check("post-reset lo", 64'(lo), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
